// File: rtl/riscv_alu_issue.sv
// riscv_alu_issue: single-issue sequencing stage for the ADD/SUB/ADDI subset.
// Accepts one instruction, reads rs1/rs2 from the register file, drives a
// registered 1-cycle ALU, then offers the result through a valid/ready
// writeback port. Any other encoding is dropped with a one-cycle o_Illegal.
//
// Ports:
//   i_CLK, i_RST                 clock, synchronous active-high reset
//   i_Instr, i_Instr_Valid       instruction input
//   o_Instr_Ready                high only while idle
//   o_RS1_Addr, o_RS2_Addr       register-file read addresses
//   i_RS1_Data, i_RS2_Data       combinational register-file read data
//   o_ALU_OP1, o_ALU_OP2         ALU operands
//   o_ALU_Control                ALU op (0=ADD, 1=SUB, all ones = idle)
//   i_ALU_Result                 registered ALU result
//   o_WB_Valid, i_WB_Ready       writeback handshake
//   o_WB_Rd, o_WB_Data           writeback destination and value
//   o_Illegal                    pulse when an instruction is dropped
module riscv_alu_issue #(
  parameter int unsigned BUS_WIDTH  = 32,
  parameter int unsigned CTRL_WIDTH = 4
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic [31:0]           i_Instr,
  input  logic                  i_Instr_Valid,
  output logic                  o_Instr_Ready,
  output logic [4:0]            o_RS1_Addr,
  output logic [4:0]            o_RS2_Addr,
  input  logic [BUS_WIDTH-1:0]  i_RS1_Data,
  input  logic [BUS_WIDTH-1:0]  i_RS2_Data,
  output logic [BUS_WIDTH-1:0]  o_ALU_OP1,
  output logic [BUS_WIDTH-1:0]  o_ALU_OP2,
  output logic [CTRL_WIDTH-1:0] o_ALU_Control,
  input  logic [BUS_WIDTH-1:0]  i_ALU_Result,
  output logic                  o_WB_Valid,
  input  logic                  i_WB_Ready,
  output logic [4:0]            o_WB_Rd,
  output logic [BUS_WIDTH-1:0]  o_WB_Data,
  output logic                  o_Illegal
);

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned IMM_W   = 12;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_ADD     = 7'b0000000;
  localparam logic [6:0] F7_SUB     = 7'b0100000;
  localparam logic [2:0] F3_ADD     = 3'b000;

  localparam logic [CTRL_WIDTH-1:0] CTRL_ADD  = CTRL_WIDTH'(0);
  localparam logic [CTRL_WIDTH-1:0] CTRL_SUB  = CTRL_WIDTH'(1);
  localparam logic [CTRL_WIDTH-1:0] CTRL_IDLE = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_WAIT,
    S_WB
  } state_e;

  state_e                  state_q, state_d;
  logic [INSTR_W-1:0]      instr_q, instr_d;
  logic [BUS_WIDTH-1:0]    op1_q, op1_d;
  logic [BUS_WIDTH-1:0]    op2_q, op2_d;
  logic [CTRL_WIDTH-1:0]   ctrl_q, ctrl_d;
  logic [REG_AW-1:0]       rd_q, rd_d;
  logic [BUS_WIDTH-1:0]    wb_data_q, wb_data_d;
  logic                    wb_valid_q, wb_valid_d;
  logic                    illegal_q, illegal_d;

  // Instruction fields of the captured word
  logic [6:0]           opcode;
  logic [2:0]           funct3;
  logic [6:0]           funct7;
  logic [BUS_WIDTH-1:0] imm_sext;

  assign opcode   = instr_q[6:0];
  assign funct3   = instr_q[14:12];
  assign funct7   = instr_q[31:25];
  assign imm_sext = {{(BUS_WIDTH-IMM_W){instr_q[31]}}, instr_q[31:20]};

  // State and datapath registers
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q    <= S_IDLE;
      instr_q    <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      ctrl_q     <= CTRL_IDLE;
      rd_q       <= '0;
      wb_data_q  <= '0;
      wb_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      ctrl_q     <= ctrl_d;
      rd_q       <= rd_d;
      wb_data_q  <= wb_data_d;
      wb_valid_q <= wb_valid_d;
      illegal_q  <= illegal_d;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    ctrl_d     = ctrl_q;
    rd_d       = rd_q;
    wb_data_d  = wb_data_q;
    wb_valid_d = wb_valid_q;
    illegal_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_Instr_Valid) begin
          instr_d = i_Instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // Register-file read addresses come from instr_q, so the read data
        // is already valid in this cycle.
        if (opcode == OPC_OP && funct3 == F3_ADD && funct7 == F7_ADD) begin
          ctrl_d  = CTRL_ADD;
          op1_d   = i_RS1_Data;
          op2_d   = i_RS2_Data;
          rd_d    = instr_q[11:7];
          state_d = S_EXEC;
        end else if (opcode == OPC_OP && funct3 == F3_ADD && funct7 == F7_SUB) begin
          ctrl_d  = CTRL_SUB;
          op1_d   = i_RS1_Data;
          op2_d   = i_RS2_Data;
          rd_d    = instr_q[11:7];
          state_d = S_EXEC;
        end else if (opcode == OPC_OP_IMM && funct3 == F3_ADD) begin
          ctrl_d  = CTRL_ADD;
          op1_d   = i_RS1_Data;
          op2_d   = imm_sext;
          rd_d    = instr_q[11:7];
          state_d = S_EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_EXEC: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // x0 is hard-wired to zero, so never write back a nonzero value to it
        wb_data_d  = (rd_q == REG_AW'(0)) ? '0 : i_ALU_Result;
        ctrl_d     = CTRL_IDLE;
        wb_valid_d = 1'b1;
        state_d    = S_WB;
      end
      S_WB: begin
        if (i_WB_Ready) begin
          wb_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_Instr_Ready = (state_q == S_IDLE) && !i_RST;
  assign o_RS1_Addr    = instr_q[19:15];
  assign o_RS2_Addr    = instr_q[24:20];
  assign o_ALU_OP1     = op1_q;
  assign o_ALU_OP2     = op2_q;
  assign o_ALU_Control = ctrl_q;
  assign o_WB_Valid    = wb_valid_q;
  assign o_WB_Rd       = rd_q;
  assign o_WB_Data     = wb_data_q;
  assign o_Illegal     = illegal_q;

endmodule

// File: doc/riscv_alu_issue.md
Name: riscv_alu_issue

Overview:
- Issue/sequencing stage that accepts one instruction at a time and decodes it.
- Fetches the register operands and drives the team's registered 2-op ALU, which has 1-cycle latency and control codes 0=ADD, 1=SUB.
- Collects the ALU result and presents it to the register-file writeback port through a valid/ready handshake.
- Sits between fetch and the register file/ALU. Supports the ADD, SUB and ADDI subset; any other instruction is flagged illegal.

Parameters:
- BUS_WIDTH, 32, data/operand width. Instruction width is fixed at 32.
- CTRL_WIDTH, 4, ALU control code width.

Ports:
- i_CLK  input  1  clock; all logic on the rising edge.
- i_RST  input  1  synchronous, active-high reset.
- i_Instr  input  32  instruction word.
- i_Instr_Valid  input  1  i_Instr is valid.
- o_Instr_Ready  output  1  block can accept an instruction.
- o_RS1_Addr  output  5  register-file read address for rs1.
- o_RS2_Addr  output  5  register-file read address for rs2.
- i_RS1_Data  input  BUS_WIDTH  combinational read data for o_RS1_Addr.
- i_RS2_Data  input  BUS_WIDTH  combinational read data for o_RS2_Addr.
- o_ALU_OP1  output  BUS_WIDTH  ALU operand 1.
- o_ALU_OP2  output  BUS_WIDTH  ALU operand 2.
- o_ALU_Control  output  CTRL_WIDTH  ALU op code.
- i_ALU_Result  input  BUS_WIDTH  ALU registered result.
- o_WB_Valid  output  1  writeback data is valid.
- i_WB_Ready  input  1  writeback consumer accepts the data.
- o_WB_Rd  output  5  destination register.
- o_WB_Data  output  BUS_WIDTH  writeback value.
- o_Illegal  output  1  one-cycle pulse when an undecodable instruction is dropped.

Behaviour:
- Reset (i_RST=1 at an edge):
  - State goes to IDLE.
  - o_ALU_OP1, o_ALU_OP2, o_WB_Data, o_WB_Rd, o_RS1_Addr, o_RS2_Addr reset to 0.
  - o_ALU_Control resets to all ones (ALU default produces 0).
  - o_WB_Valid and o_Illegal reset to 0.
  - o_Instr_Ready is 0 while i_RST=1.
- Reset mid-operation: reset at any state aborts the instruction, produces no writeback and no o_Illegal, and returns to IDLE.
- FSM states: IDLE, DECODE, EXEC, WAIT, WB.
  - o_Instr_Ready = 1 only in IDLE (decoded from state).
- IDLE: when i_Instr_Valid and o_Instr_Ready at edge T, capture i_Instr, drive o_RS1_Addr=instr[19:15] and o_RS2_Addr=instr[24:20], go to DECODE.
- DECODE (cycle T+1): decode the captured instruction.
  - opcode 0110011, funct3 000, funct7 0000000 → ADD: control 0, OP1=rs1, OP2=rs2.
  - opcode 0110011, funct3 000, funct7 0100000 → SUB: control 1, OP1=rs1, OP2=rs2.
  - opcode 0010011, funct3 000 → ADDI: control 0, OP1=rs1, OP2=sign-extended instr[31:20].
  - Valid decode: at end of T+1 register OP1/OP2/control and o_WB_Rd=instr[11:7], then go to EXEC.
  - Anything else: o_Illegal=1 during T+2 only, return to IDLE, no ALU issue, no writeback.
- EXEC (T+2): ALU inputs are stable; the ALU registers its result at end of T+2. Go to WAIT.
- WAIT (T+3): capture i_ALU_Result into o_WB_Data at end of T+3.
  - If rd=0, o_WB_Data is forced to 0.
  - Return o_ALU_Control to all ones, go to WB.
- WB (T+4 onward):
  - o_WB_Valid=1; o_WB_Rd and o_WB_Data held stable until i_WB_Ready=1 at an edge.
  - On that edge: o_WB_Valid goes to 0 and state goes to IDLE.
  - Ready asserted in the same cycle valid rises completes the transfer in one cycle.
- Timing:
  - Minimum issue interval is 5 cycles; one instruction is in flight at most.
  - i_Instr is ignored outside IDLE.
- Arithmetic: modulo 2^BUS_WIDTH and performed by the ALU; this block does no arithmetic except ADDI immediate sign extension.
- Idle outputs: o_ALU_OP1/OP2 hold their last values outside EXEC.

Test Plan:
- ADD x3,x1,x2 with RS1=5, RS2=7, accepted at T → o_WB_Valid at T+4, o_WB_Rd=3, o_WB_Data=12; o_ALU_Control=0 during T+2.
- SUB x4,x1,x2 with RS1=5, RS2=7 → o_ALU_Control=1 at T+2; writeback rd=4, data=0xFFFFFFFE.
- ADDI x5,x6,-1 (imm 0xFFF) with RS1=10 → o_ALU_OP2=0xFFFFFFFF at T+2; writeback data=9.
- Illegal LW (opcode 0000011) → o_Illegal=1 for exactly cycle T+2, no o_WB_Valid, o_Instr_Ready=1 again at T+2.
- ADD with i_WB_Ready held low 3 cycles after valid → valid, rd and data stable throughout, o_Instr_Ready=0; completes on the first ready edge, IDLE next cycle.
- i_RST pulsed during WAIT → o_WB_Valid never asserts, all outputs at reset values. ADD rd=0 (RS1=1, RS2=1) → writeback rd=0, data=0.
